// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for the 256x16 RAM plus LED/switch I/O.
// Each transaction runs IDLE -> ACCESS (-> RDATA for RAM reads) -> IDLE.
module mem_arbiter #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [1:0]  cmd0,
  input  logic [8:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic [1:0]  cmd1,
  input  logic [8:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [7:0]  ram_addr,
  output logic        ram_write,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [7:0]  sw_in,
  output logic [7:0]  ledr
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        last_q;
  logic        win_q;
  logic [1:0]  cmd_q;
  logic [8:0]  addr_q;
  logic [15:0] wd_q;
  logic [7:0]  ledr_q;

  logic        valid0;
  logic        valid1;
  logic        any_valid;
  logic        win_d;
  logic [1:0]  win_cmd;
  logic [8:0]  win_addr;
  logic [15:0] win_wd;

  logic        is_rd;
  logic        is_wr;
  logic        is_ram;
  logic        acc_led;
  logic        acc_sw;
  logic        done;
  logic        ack_live;
  logic [15:0] rd_val;

  assign valid0    = req0 & ((cmd0 == MREAD) | (cmd0 == MWRITE));
  assign valid1    = req1 & ((cmd1 == MREAD) | (cmd1 == MWRITE));
  assign any_valid = valid0 | valid1;

  // On a tie the port that was not served last wins.
  assign win_d    = (valid0 & valid1) ? ~last_q : valid1;
  assign win_cmd  = win_d ? cmd1   : cmd0;
  assign win_addr = win_d ? addr1  : addr0;
  assign win_wd   = win_d ? wdata1 : wdata0;

  assign is_rd   = (cmd_q == MREAD);
  assign is_wr   = (cmd_q == MWRITE);
  assign is_ram  = ~addr_q[8];
  assign acc_led = is_wr & (addr_q == LED_ADDR);
  assign acc_sw  = is_rd & (addr_q == SW_ADDR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = any_valid ? ACCESS : IDLE;
      ACCESS:  state_d = (is_ram & is_rd) ? RDATA : IDLE;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done   = 1'b0;
    rd_val = 16'h0000;
    unique case (1'b1)
      (state_q == ACCESS): begin
        done = ~(is_ram & is_rd);
        if (acc_sw)
          rd_val = {8'h00, sw_in};
      end
      (state_q == RDATA): begin
        done   = 1'b1;
        rd_val = ram_rdata;
      end
      default: ;
    endcase
  end

  // A reset landing mid-transaction swallows the ack and the RAM strobe.
  assign ack_live  = done & ~reset;
  assign ack0      = ack_live & ~win_q;
  assign ack1      = ack_live & win_q;
  assign rdata     = ack_live ? rd_val : 16'h0000;

  assign ram_addr  = addr_q[7:0];
  assign ram_wdata = wd_q;
  assign ram_write = (state_q == ACCESS) & is_wr & is_ram & ~reset;
  assign ledr      = ledr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      cmd_q   <= MNONE;
      addr_q  <= 9'h000;
      wd_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) & any_valid) begin
        win_q  <= win_d;
        last_q <= win_d;
        cmd_q  <= win_cmd;
        addr_q <= win_addr;
        wd_q   <= win_wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ledr_q <= 8'h00;
    else if ((state_q == ACCESS) & acc_led)
      ledr_q <= wd_q[7:0];
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic,
// checked each cycle against a transaction-level schedule model.
module tb_mem_arbiter;

  localparam logic [8:0] LED_A = 9'h100;
  localparam logic [8:0] SW_A  = 9'h140;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [7:0]  ledr;

  always #5 clk = ~clk;

  mem_arbiter #(.LED_ADDR(LED_A), .SW_ADDR(SW_A)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .ledr(ledr)
  );

  // Environment RAM with a registered read port.
  logic [15:0] ram [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_write) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  logic rq [2];
  txn_t cur [2];
  assign req0   = rq[0];
  assign cmd0   = cur[0].cmd;
  assign addr0  = cur[0].addr;
  assign wdata0 = cur[0].wd;
  assign req1   = rq[1];
  assign cmd1   = cur[1].cmd;
  assign addr1  = cur[1].addr;
  assign wdata1 = cur[1].wd;

  txn_t q0[$];
  txn_t q1[$];
  bit act [2];
  bit rand_mode, force_rst, sw_hold;
  int junk0;

  logic [15:0] ref_mem [256] = '{default: 16'h0000};
  int n, idle_from, ack_cyc, ack_port, wr_cyc, led_cyc;
  logic [15:0] ack_data, wr_data;
  logic [7:0]  wr_addr, led_val, ledr_m;
  bit ack_sw, last_m;
  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, n, got, exp);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.cmd = 2'($urandom_range(1, 2));
    case ($urandom_range(0, 5))
      0, 1, 2: t.addr = {5'b0, 4'($urandom)};
      3:       t.addr = LED_A;
      4:       t.addr = SW_A;
      default: t.addr = {1'b1, 8'($urandom)};
    endcase
    t.wd = 16'($urandom);
    return t;
  endfunction

  function automatic txn_t junk_txn(logic [1:0] c);
    txn_t t;
    t.cmd  = c;
    t.addr = 9'($urandom);
    t.wd   = 16'($urandom);
    return t;
  endfunction

  task automatic drive_port(input int p);
    int r;
    if (act[p]) return;
    if (p == 0 && q0.size() > 0) begin
      cur[0] = q0.pop_front(); rq[0] = 1'b1; act[0] = 1'b1;
    end else if (p == 1 && q1.size() > 0) begin
      cur[1] = q1.pop_front(); rq[1] = 1'b1; act[1] = 1'b1;
    end else if (p == 0 && junk0 > 0) begin
      junk0--;
      cur[0] = junk_txn(2'b11); rq[0] = 1'b1;
    end else if (rand_mode) begin
      r = $urandom_range(0, 9);
      if (r >= 5) begin
        cur[p] = rand_txn(); rq[p] = 1'b1; act[p] = 1'b1;
      end else if (r == 4) begin
        cur[p] = junk_txn($urandom_range(0, 1) ? 2'b11 : 2'b00);
        rq[p]  = 1'b1;
      end else begin
        cur[p] = junk_txn(2'($urandom)); rq[p] = 1'b0;
      end
    end else begin
      cur[p] = junk_txn(2'b00); rq[p] = 1'b0;
    end
  endtask

  task automatic check_cycle();
    bit e_ack, e_wr;
    logic [15:0] e_rd;
    e_ack = !reset && (n == ack_cyc);
    e_wr  = !reset && (n == wr_cyc);
    e_rd  = !e_ack ? 16'h0000 : (ack_sw ? {8'h00, sw_in} : ack_data);
    check("ack0", ack0, e_ack && ack_port == 0);
    check("ack1", ack1, e_ack && ack_port == 1);
    check("rdata", rdata, e_rd);
    check("ram_write", ram_write, e_wr);
    if (e_wr) begin
      check("ram_addr", ram_addr, wr_addr);
      check("ram_wdata", ram_wdata, wr_data);
    end
    check("ledr", ledr, ledr_m);
  endtask

  task automatic model_update();
    bit v0, v1, w;
    txn_t t;
    if (reset) begin
      idle_from = n + 1; last_m = 1'b1; ledr_m = 8'h00;
      ack_cyc = -1; wr_cyc = -1; led_cyc = -1;
      act[0] = 1'b0; act[1] = 1'b0;
      return;
    end
    if (n == ack_cyc) act[ack_port] = 1'b0;
    if (n == wr_cyc) ref_mem[wr_addr] = wr_data;
    if (n == led_cyc) ledr_m = led_val;
    if (n < idle_from) return;
    v0 = rq[0] && (cur[0].cmd == 2'b01 || cur[0].cmd == 2'b10);
    v1 = rq[1] && (cur[1].cmd == 2'b01 || cur[1].cmd == 2'b10);
    if (!(v0 || v1)) return;
    w = (v0 && v1) ? !last_m : v1;
    last_m = w;
    t = cur[w];
    ack_port = int'(w);
    ack_sw = 1'b0;
    ack_data = 16'h0000;
    if (!t.addr[8] && t.cmd == 2'b10) begin
      wr_cyc = n + 1; wr_addr = t.addr[7:0]; wr_data = t.wd;
      ack_cyc = n + 1; idle_from = n + 2;
    end else if (!t.addr[8]) begin
      ack_data = ref_mem[t.addr[7:0]];
      ack_cyc = n + 2; idle_from = n + 3;
    end else begin
      ack_cyc = n + 1; idle_from = n + 2;
      if (t.cmd == 2'b10 && t.addr == LED_A) begin
        led_cyc = n + 1; led_val = t.wd[7:0];
      end
      if (t.cmd == 2'b01 && t.addr == SW_A) ack_sw = 1'b1;
    end
  endtask

  task automatic step();
    reset = force_rst || (rand_mode && $urandom_range(0, 299) == 0);
    if (!sw_hold) sw_in = 8'($urandom);
    drive_port(0);
    drive_port(1);
    @(negedge clk);
    check_cycle();
    model_update();
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((act[0] || act[1] || q0.size() > 0 || q1.size() > 0) && k < 60) begin
      step();
      k++;
    end
    check("drain_bound", k < 60, 1);
  endtask

  function automatic txn_t mk(logic [1:0] c, logic [8:0] a, logic [15:0] d);
    txn_t t;
    t.cmd = c; t.addr = a; t.wd = d;
    return t;
  endfunction

  initial begin
    n = 0; idle_from = 0; ack_cyc = -1; ack_port = 0;
    wr_cyc = -1; led_cyc = -1; ledr_m = 8'h00; last_m = 1'b1;
    ack_data = 16'h0; wr_data = 16'h0; wr_addr = 8'h0; led_val = 8'h0;
    ack_sw = 1'b0; rand_mode = 1'b0; force_rst = 1'b0; sw_hold = 1'b0;
    junk0 = 0; act[0] = 1'b0; act[1] = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    cur[0] = mk(2'b00, 9'h0, 16'h0); cur[1] = mk(2'b00, 9'h0, 16'h0);
    sw_in = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ledr", ledr, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);

    q0.push_back(mk(2'b10, 9'h005, 16'hBEEF)); drain();
    q0.push_back(mk(2'b01, 9'h005, 16'h0000)); drain();

    q0.push_back(mk(2'b10, 9'h010, 16'h1111));
    q1.push_back(mk(2'b10, 9'h011, 16'h2222)); drain();
    q0.push_back(mk(2'b10, 9'h010, 16'h3333));
    q1.push_back(mk(2'b10, 9'h011, 16'h4444)); drain();

    q1.push_back(mk(2'b10, LED_A, 16'h00A5)); drain();
    check("ledr_a5", ledr, 8'hA5);
    q1.push_back(mk(2'b10, SW_A, 16'h0077)); drain();
    check("ledr_kept", ledr, 8'hA5);

    sw_hold = 1'b1; sw_in = 8'h3C;
    q0.push_back(mk(2'b01, SW_A, 16'h0)); drain();
    q0.push_back(mk(2'b01, 9'h1FF, 16'h0)); drain();
    q1.push_back(mk(2'b01, LED_A, 16'h0)); drain();
    sw_hold = 1'b0;

    junk0 = 10;
    repeat (10) step();

    q0.push_back(mk(2'b10, 9'h020, 16'h1234));
    step();
    force_rst = 1'b1; step(); force_rst = 1'b0;
    check("abort_ram_addr", ram_addr, 0);
    check("abort_ram_wdata", ram_wdata, 0);
    step();
    q0.push_back(mk(2'b01, 9'h020, 16'h0)); drain();

    q0.push_back(mk(2'b10, LED_A, 16'h00FF));
    step();
    force_rst = 1'b1; step(); force_rst = 1'b0;
    check("abort_ledr", ledr, 0);
    step();

    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
